// File: rtl/mips_alu_md.sv
// Execute-stage ALU with a valid/ready request/response handshake and optional iterative mul/div owning HI/LO.
// Define MIPS_ALU_MULDIV_EN to build the radix-2 multiply/divide unit; without it ops 11-14 return 0 in one cycle.
module mips_alu_md #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] src1,
    input  logic [W-1:0] src2,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         ovf,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy
);
    localparam int SHW = $clog2(W);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_NOR   = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,  OP_SRL   = 4'd9,  OP_SRA  = 4'd10, OP_MULT = 4'd11,
        OP_MULTU = 4'd12, OP_DIV  = 4'd13, OP_DIVU = 4'd14, OP_RSVD = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP
`ifdef MIPS_ALU_MULDIV_EN
        , S_ITER
`endif
    } state_e;

    state_e         r_state;
    logic [W-1:0]   r_result;
    logic           r_zero;
    logic           r_ovf;

    op_e            w_op;
    logic           w_accept;
    logic [SHW-1:0] w_shamt;
    logic [W-1:0]   w_sum;
    logic [W-1:0]   w_diff;
    logic [W-1:0]   w_alu_res;
    logic           w_alu_ovf;

    assign w_op     = op_e'(op);
    assign w_shamt  = src2[SHW-1:0];
    assign w_sum    = src1 + src2;
    assign w_diff   = src1 - src2;

    assign req_ready  = (r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready);
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign result     = r_result;
    assign zero       = r_zero;
    assign ovf        = r_ovf;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missing branch would otherwise infer a latch.
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (src1[W-1] == src2[W-1]) && (w_sum[W-1] != src1[W-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (src1[W-1] != src2[W-1]) && (w_diff[W-1] != src1[W-1]);
            end
            OP_AND:  w_alu_res = src1 & src2;
            OP_OR:   w_alu_res = src1 | src2;
            OP_XOR:  w_alu_res = src1 ^ src2;
            OP_NOR:  w_alu_res = ~(src1 | src2);
            OP_SLT:  w_alu_res = {{(W-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_SLTU: w_alu_res = {{(W-1){1'b0}}, (src1 < src2)};
            OP_SLL:  w_alu_res = src1 << w_shamt;
            OP_SRL:  w_alu_res = src1 >> w_shamt;
            OP_SRA:  w_alu_res = $signed(src1) >>> w_shamt;
            default: ;
        endcase
    end

`ifdef MIPS_ALU_MULDIV_EN
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(W);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    // r_wa: product high / partial remainder; r_wb: multiplier / dividend shifting into quotient.
    logic [SHW:0]   r_cnt;
    logic [W-1:0]   r_wa;
    logic [W-1:0]   r_wb;
    logic [W-1:0]   r_opb;
    logic [W-1:0]   r_src1;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_is_div;
    logic           r_neg_res;
    logic           r_neg_rem;
    logic           r_dz;

    logic           w_md_op;
    logic           w_signed_md;
    logic [W-1:0]   w_abs1;
    logic [W-1:0]   w_abs2;
    logic [W:0]     w_msum;
    logic [W:0]     w_shift;
    logic [W:0]     w_ddiff;
    logic [W-1:0]   w_nxt_wa;
    logic [W-1:0]   w_nxt_wb;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_fin_hi;
    logic [W-1:0]   w_fin_lo;

    assign w_md_op     = (w_op == OP_MULT) || (w_op == OP_MULTU) || (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_signed_md = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_abs1      = (w_signed_md && src1[W-1]) ? -src1 : src1;
    assign w_abs2      = (w_signed_md && src2[W-1]) ? -src2 : src2;

    // Magnitudes iterate unsigned; signs are re-applied on the final step.
    assign w_msum   = {1'b0, r_wa} + (r_wb[0] ? {1'b0, r_opb} : '0);
    assign w_shift  = {r_wa, r_wb[W-1]};
    assign w_ddiff  = w_shift - {1'b0, r_opb};
    assign w_nxt_wa = r_is_div ? (w_ddiff[W] ? w_shift[W-1:0] : w_ddiff[W-1:0]) : w_msum[W:1];
    assign w_nxt_wb = r_is_div ? {r_wb[W-2:0], ~w_ddiff[W]} : {w_msum[0], r_wb[W-1:1]};
    assign w_prod   = r_neg_res ? -{w_nxt_wa, w_nxt_wb} : {w_nxt_wa, w_nxt_wb};

    always_comb begin
        w_fin_hi = w_prod[2*W-1:W];
        w_fin_lo = w_prod[W-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_fin_hi = r_src1;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = r_neg_rem ? -w_nxt_wa : w_nxt_wa;
                w_fin_lo = r_neg_res ? -w_nxt_wb : w_nxt_wb;
            end
        end
    end

    assign busy = (r_state == S_ITER);
    assign hi   = r_hi;
    assign lo   = r_lo;
`else
    assign busy = 1'b0;
    assign hi   = '0;
    assign lo   = '0;
`endif

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef MIPS_ALU_MULDIV_EN
            r_cnt     <= '0;
            r_wa      <= '0;
            r_wb      <= '0;
            r_opb     <= '0;
            r_src1    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
`endif
        end else begin
            case (r_state)
`ifdef MIPS_ALU_MULDIV_EN
                S_ITER: begin
                    r_wa  <= w_nxt_wa;
                    r_wb  <= w_nxt_wb;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_hi     <= w_fin_hi;
                        r_lo     <= w_fin_lo;
                        r_result <= w_fin_lo;
                        r_zero   <= (w_fin_lo == '0);
                        r_ovf    <= 1'b0;
                        r_state  <= S_RESP;
                    end
                end
`endif
                default: begin
                    if (w_accept) begin
`ifdef MIPS_ALU_MULDIV_EN
                        if (w_md_op) begin
                            r_state   <= S_ITER;
                            r_cnt     <= CNT_INIT;
                            r_wa      <= '0;
                            r_wb      <= w_abs1;
                            r_opb     <= w_abs2;
                            r_src1    <= src1;
                            r_is_div  <= (w_op == OP_DIV) || (w_op == OP_DIVU);
                            r_neg_res <= w_signed_md && (src1[W-1] ^ src2[W-1]);
                            r_neg_rem <= w_signed_md && src1[W-1];
                            r_dz      <= (src2 == '0);
                        end else
`endif
                        begin
                            r_state  <= S_RESP;
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                            r_ovf    <= w_alu_ovf;
                        end
                    end else if ((r_state == S_RESP) && resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_md.sv
// Scoreboard bench for mips_alu_md: accepted requests push a model result, a monitor pops on each response.
// Expectations follow MIPS_ALU_MULDIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_mips_alu_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;

    mips_alu_md #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .src1(src1), .src2(src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result(result), .zero(zero), .ovf(ovf),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    longint      cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          seen = 1'b0;
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] p;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        e.result = '0;
        e.ovf = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (o)
            4'd0: begin s = sa + sb; e.result = s[31:0]; e.ovf = (s != longint'($signed(s[31:0]))); end
            4'd1: begin s = sa - sb; e.result = s[31:0]; e.ovf = (s != longint'($signed(s[31:0]))); end
            4'd2: e.result = a & b;
            4'd3: e.result = a | b;
            4'd4: e.result = a ^ b;
            4'd5: e.result = ~(a | b);
            4'd6: e.result = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: e.result = (a < b) ? 32'd1 : 32'd0;
            4'd8: e.result = a << sh;
            4'd9: e.result = a >> sh;
            4'd10: e.result = $signed(a) >>> sh;
            4'd11, 4'd12, 4'd13, 4'd14: begin
`ifdef MIPS_ALU_MULDIV_EN
                if (o == 4'd11) begin
                    p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0];
                end else if (o == 4'd12) begin
                    p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0];
                end else if (b == 32'd0) begin
                    m_lo = '1; m_hi = a;
                end else if (o == 4'd13) begin
                    s = sa / sb; m_lo = s[31:0];
                    s = sa % sb; m_hi = s[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                e.result = m_lo;
                e.lat = W + 1;
`endif
            end
            default: ;
        endcase
        e.zero = (e.result == 32'd0);
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #2;
            resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin : watcher
        exp_t e;
        if (rst_n && req_valid && req_ready) begin
            e = model(op, src1, src2);
            e.acc = cyc;
            sbq.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (resp_valid) begin
            if (sbq.size() == 0) begin
                check("resp_without_request", 64'(sbq.size()), 64'd1);
            end else begin
                if (!seen) begin
                    check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                    seen = 1'b1;
                end
                check("req_ready_in_resp", 64'(req_ready), 64'(resp_ready));
                check("busy_in_resp", 64'(busy), 64'd0);
                if (resp_ready) begin
                    e = sbq.pop_front();
                    check("result", 64'(result), 64'(e.result));
                    check("zero", 64'(zero), 64'(e.zero));
                    check("ovf", 64'(ovf), 64'(e.ovf));
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    seen = 1'b0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        op = o; src1 = a; src2 = b; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (sbq.size() != 0) check("drain_timeout", 64'(sbq.size()), 64'd0);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_busy, k;
        logic [31:0] ha, hb, hexp;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_ovf_result", 64'(result), 64'h8000_0000);
        check("add_ovf_flag", 64'(ovf), 64'd1);
        check("add_ovf_zero", 64'(zero), 64'd0);
        issue(4'd1, 32'd5, 32'd5);
        issue(4'd10, 32'hF000_0000, 32'd4);
        issue(4'd7, 32'd1, 32'hFFFF_FFFF);
        issue(4'd6, 32'd1, 32'hFFFF_FFFF);
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'd8, 32'd1, 32'd31);
        issue(4'd9, 32'h8000_0000, 32'd31);
        issue(4'd5, 32'd0, 32'd0);
        drain();

`ifdef MIPS_ALU_MULDIV_EN
        issue(4'd11, 32'hFFFF_FFFD, 32'd7);
        n_busy = 0;
        k = 0;
        while (!resp_valid && k < 100) begin
            @(negedge clk);
            if (busy) n_busy++;
            k++;
        end
        check("mult_busy_cycles", 64'(n_busy), 64'd32);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(posedge clk);
        #1;
`else
        issue(4'd11, 32'hFFFF_FFFD, 32'd7);
`endif
        issue(4'd13, 32'hFFFF_FFF9, 32'd2);
        issue(4'd14, 32'd9, 32'd0);
        issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(4'd13, 32'h0000_0007, 32'hFFFF_FFFE);
        drain();

        resp_ready = 1'b0;
        ha = $urandom;
        hb = $urandom;
        hexp = ha + hb;
        issue(4'd0, ha, hb);
        repeat (5) begin
            @(negedge clk);
            check("hold_result", 64'(result), 64'(hexp));
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        ha = $urandom;
        hb = $urandom;
        issue(4'd2, ha, hb);
        @(negedge clk);
        check("b2b_and_result", 64'(result), 64'(ha & hb));
        check("b2b_resp_valid", 64'(resp_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick());
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #3;
        resp_ready = 1'b1;
        drain();

        issue(4'd11, 32'hFFFF_FFFD, 32'd7);
        drain();
        issue(4'd14, $urandom | 32'h8000_0000, 32'($urandom_range(1, 255)));
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy", 64'(busy), 64'd0);
        check("midop_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("midop_rst_hi", 64'(hi), 64'd0);
        check("midop_rst_lo", 64'(lo), 64'd0);
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 20; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick());
        end
        drain();
        check("queue_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
